// File: rtl/tf_table_loader.sv
// tf_table_loader: streams twiddle-factor words into the BRAM write port with count, checksum and overflow reporting
module tf_table_loader #(
  parameter int float_len        = 32,
  parameter int tf_num           = 2048,
  parameter int bram_tf_addr_len = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [2*float_len-1:0]        in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          bram_we,
  output logic [bram_tf_addr_len-1:0]   bram_addr,
  output logic [2*float_len-1:0]        bram_din,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow_err,
  output logic [bram_tf_addr_len:0]     words_loaded,
  output logic [2*float_len-1:0]        checksum
);
  localparam int WL = bram_tf_addr_len + 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic xfer;
  logic last;
  assign busy     = state == LOAD;
  assign done     = state == DONE;
  // abort gates acceptance combinationally so an aborted word is never written
  assign in_ready = busy & ~abort;
  assign xfer     = in_valid & in_ready;
  assign last     = words_loaded == WL'(tf_num - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_din     <= '0;
      overflow_err <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      bram_we <= xfer;
      if (xfer) begin
        bram_addr    <= words_loaded[bram_tf_addr_len-1:0];
        bram_din     <= in_data;
        words_loaded <= words_loaded + 1'b1;
        checksum     <= checksum ^ in_data;
      end
      if (state == LOAD) begin
        state <= abort ? IDLE : (xfer && last) ? DONE : LOAD;
      end else if (start) begin
        state        <= LOAD;
        words_loaded <= '0;
        checksum     <= '0;
        overflow_err <= 1'b0;
      end else if (state == DONE) begin
        overflow_err <= overflow_err | in_valid;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_tf_table_loader.sv
// tb_tf_table_loader: directed self-checking bench for the twiddle-factor table loader
module tb_tf_table_loader;
  localparam int FL = 32;
  localparam int N  = 2048;
  localparam int AW = 11;
  logic clk = 1'b0;
  logic rst, start, abort, in_valid;
  logic [2*FL-1:0] in_data;
  logic in_ready, bram_we, busy, done, overflow_err;
  logic [AW-1:0] bram_addr;
  logic [2*FL-1:0] bram_din, checksum;
  logic [AW:0] words_loaded;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tf_table_loader #(.float_len(FL), .tf_num(N), .bram_tf_addr_len(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .busy(busy), .done(done), .overflow_err(overflow_err),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, bram_we, bram_addr, bram_din, busy, done, overflow_err, words_loaded, checksum} !== '0) begin
        errors++;
        $display("FAIL reset: outputs we=%b rdy=%b busy=%b done=%b ovf=%b wl=%0d cs=%h, all required 0",
                 bram_we, in_ready, busy, done, overflow_err, words_loaded, checksum);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, bram_we, busy, overflow_err, words_loaded} !== '0) begin
      errors++;
      $display("FAIL idle_ignore: rdy=%b we=%b busy=%b ovf=%b wl=%0d, all required 0",
               in_ready, bram_we, busy, overflow_err, words_loaded);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_load(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= N; i++) begin
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== AW'(i - 1) || bram_din !== 64'(i - 1)) begin
          errors++;
          $display("FAIL %s write %0d: we=%b addr=%0d din=%0h, required we=1 addr=%0d din=%0h",
                   tag, i - 1, bram_we, bram_addr, bram_din, i - 1, i - 1);
        end
      end
      if (i < N) begin
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s ready %0d: rdy=%b busy=%b done=%b, required 1 1 0", tag, i, in_ready, busy, done);
        end
        in_valid = 1'b1;
        in_data  = 64'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || words_loaded !== 12'd2048 || checksum !== '0) begin
      errors++;
      $display("FAIL %s complete: done=%b busy=%b rdy=%b wl=%0d cs=%h, required 1 0 0 2048 0",
               tag, done, busy, in_ready, words_loaded, checksum);
    end
    @(negedge clk);
    checks++;
    if (bram_we !== 1'b0 || done !== 1'b1 || words_loaded !== 12'd2048) begin
      errors++;
      $display("FAIL %s hold: we=%b done=%b wl=%0d, required 0 1 2048", tag, bram_we, done, words_loaded);
    end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_data = 64'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow_err !== 1'b1 || bram_we !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b we=%b done=%b, required 1 0 1", overflow_err, bram_we, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (overflow_err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: ovf=%b done=%b, required 1 1", overflow_err, done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (overflow_err !== 1'b0 || done !== 1'b0 || words_loaded !== '0 || checksum !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b done=%b wl=%0d cs=%h busy=%b, required 0 0 0 0 1",
               overflow_err, done, words_loaded, checksum, busy);
    end
  endtask

  task automatic test_back_to_back();
    // already in LOAD with an empty table; start mid-stream must be ignored
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        @(negedge clk);
        checks++;
        if (bram_we !== 1'b1 || bram_addr !== AW'(i - 1) || bram_din !== 64'(16 + i - 1)) begin
          errors++;
          $display("FAIL b2b write %0d: we=%b addr=%0d din=%0h, required 1 %0d %0h",
                   i - 1, bram_we, bram_addr, bram_din, i - 1, 16 + i - 1);
        end
      end
      start    = (i == 1);
      in_valid = (i < 3);
      in_data  = 64'(16 + i);
    end
    start = 1'b1; abort = 1'b1; in_valid = 1'b1; in_data = 64'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_gate: rdy=%b, required 0", in_ready);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || bram_we !== 1'b0 || words_loaded !== 12'd3 || checksum !== 64'(16 ^ 17 ^ 18) || done !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: busy=%b we=%b wl=%0d cs=%h done=%b, required 0 0 3 %h 0",
               busy, bram_we, words_loaded, checksum, done, 64'(16 ^ 17 ^ 18));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_restart: busy=%b rdy=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_throttled();
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [2*FL-1:0] exp_din, exp_cs;
    int k;
    exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_cs = '0; k = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++;
        if (bram_we !== exp_we || (exp_we && (bram_addr !== exp_addr || bram_din !== exp_din))) begin
          errors++;
          $display("FAIL throttle cycle %0d: we=%b addr=%0d din=%0h, required we=%b addr=%0d din=%0h",
                   c, bram_we, bram_addr, bram_din, exp_we, exp_addr, exp_din);
        end
      end
      if (c < 16) begin
        in_valid = (c % 2 == 0);
        in_data  = 64'(8'hA5 + c / 2);
        exp_we   = in_valid;
        exp_addr = AW'(k);
        exp_din  = in_data;
        if (in_valid) begin
          exp_cs = exp_cs ^ in_data;
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (words_loaded !== 12'd8 || checksum !== exp_cs || busy !== 1'b1) begin
      errors++;
      $display("FAIL throttle totals: wl=%0d cs=%h busy=%b, required 8 %h 1", words_loaded, checksum, busy, exp_cs);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      @(negedge clk);
    end
    checks++;
    if (bram_we !== 1'b1 || bram_addr !== AW'(99) || words_loaded !== 12'd100) begin
      errors++;
      $display("FAIL pre_abort: we=%b addr=%0d wl=%0d, required 1 99 100", bram_we, bram_addr, words_loaded);
    end
    abort = 1'b1; in_data = 64'd100;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (bram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words_loaded !== 12'd100) begin
      errors++;
      $display("FAIL abort: we=%b busy=%b done=%b wl=%0d, required 0 0 0 100", bram_we, busy, done, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_throttled();
    test_abort();
    test_full_load("reload");
    test_overflow();
    test_back_to_back();
    test_full_load("full");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/tf_table_loader.md
Name: tf_table_loader

Overview:
- Writer-side companion to the twiddle-factor provider.
- Accepts a stream of complex twiddle-factor words (real/imag floats packed into 2*float_len bits) over a valid/ready handshake.
- Writes the words sequentially into the write port of the twiddle-factor BRAM, starting at address 0, so the table can be reloaded at run time.
- Reports completion, the word count, an XOR checksum and a sticky overflow flag.

Parameters:
float_len, 32, width of one float; a word is 2*float_len bits
tf_num, 2048, number of twiddle factors per table
bram_tf_addr_len, 11, BRAM address width; 2^bram_tf_addr_len = tf_num

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins or restarts a table load
abort  input  1  cancel the load in progress
in_data  input  2*float_len  twiddle-factor word (imag in upper half, real in lower half)
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a word this cycle
bram_we  output  1  BRAM write enable
bram_addr  output  bram_tf_addr_len  BRAM write address
bram_din  output  2*float_len  BRAM write data
busy  output  1  load in progress
done  output  1  full table written
overflow_err  output  1  sticky; a word was offered after completion
words_loaded  output  bram_tf_addr_len+1  count of accepted words
checksum  output  2*float_len  XOR of all accepted words

Behaviour:
- Reset: clk-synchronous, rst=1. State goes to IDLE. Every output is 0: in_ready, bram_we, bram_addr, bram_din, busy, done, overflow_err, words_loaded, checksum. Reset asserted mid-load discards the partial load; no BRAM write occurs in the cycle after reset.
- States: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored and does not set an error.
  - start=1 -> LOAD next cycle. words_loaded and checksum clear to 0; overflow_err clears.
- LOAD:
  - busy=1, in_ready=1.
  - A transfer occurs when in_valid=1 and in_ready=1.
  - Each transfer is registered. On the next cycle: bram_we=1, bram_addr=words_loaded (pre-increment value), bram_din=in_data. words_loaded increments and checksum ^= in_data.
  - Write latency is exactly 1 cycle from acceptance. bram_we is 0 in any cycle following a non-transfer.
  - Back-to-back transfers produce consecutive addresses with no bubbles.
  - Transfer of word number tf_num (words_loaded==tf_num-1 before accept) -> DONE next cycle. in_ready is 0 from that cycle on. Accepted words never exceed tf_num.
  - start during LOAD is ignored.
  - abort=1 -> IDLE next cycle. A word transferred in the same cycle is NOT accepted: in_ready is gated by abort combinationally, so no write is issued. words_loaded and checksum keep their last values; done stays 0.
  - abort and start together in LOAD: abort wins.
- DONE:
  - done=1, busy=0, in_ready=0. The final BRAM write (address tf_num-1) is issued in the first DONE cycle.
  - in_valid=1 sets overflow_err=1. It is sticky until start or rst.
  - start=1 -> LOAD. done drops next cycle; words_loaded, checksum and overflow_err clear.
  - abort is ignored in DONE and IDLE.
- Address arithmetic:
  - bram_addr is the low bram_tf_addr_len bits of words_loaded.
  - words_loaded holds tf_num at completion (one extra bit), so there is no wrap to 0 on the last write.
- done, checksum and words_loaded stay stable until the next start or rst. The twiddle-factor provider may be enabled once done=1.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with in_valid=1 -> all outputs 0, bram_we never asserted.
- Full load: start pulse, then 2048 back-to-back words with value i (i=0..2047) -> bram_we on 2048 consecutive cycles, addr 0..2047, data i, 1-cycle lag. done=1 with the last write, words_loaded=2048, checksum=0 (XOR of 0..2047), in_ready=0 after the last accept.
- Throttled source: in_valid toggles 1,0,1,0 over 8 words 0xA5.. -> bram_we pattern matches accepts delayed 1 cycle, addresses 0..7 contiguous, checksum equals XOR of the 8 words.
- Abort mid-load: abort at word 100 with in_valid=1 -> that word is not written, IDLE next cycle, words_loaded=100, done=0. A following start plus 2048 words completes normally from address 0.
- Overflow: after done, in_valid=1 for 1 cycle -> overflow_err=1, no write, done stays 1. A start clears overflow_err, done and words_loaded the next cycle.
- Start+abort same cycle during LOAD -> state IDLE, no restart. Start during LOAD alone -> ignored, addresses continue sequentially.
